// File: rtl/ienc_pkg.sv
// Shared instruction-encoding definitions: symbolic ops, opcodes, field positions
// and word builders used by the loader, the decoder and the bench.
package ienc_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'd0,
    OP_LW   = 4'd1,
    OP_SW   = 4'd2,
    OP_JR   = 4'd3,
    OP_JAL  = 4'd4,
    OP_NOR  = 4'd5,
    OP_NORI = 4'd6,
    OP_NOT  = 4'd7,
    OP_BLEU = 4'd8,
    OP_ROLV = 4'd9,
    OP_RORV = 4'd10
  } op_e;

  localparam logic [5:0] OPC_AND  = 6'b100000;
  localparam logic [5:0] OPC_LW   = 6'b100011;
  localparam logic [5:0] OPC_SW   = 6'b101011;
  localparam logic [5:0] OPC_JR   = 6'b001000;
  localparam logic [5:0] OPC_JAL  = 6'b000011;
  localparam logic [5:0] OPC_NOR  = 6'b100110;
  localparam logic [5:0] OPC_NORI = 6'b001110;
  localparam logic [5:0] OPC_NOT  = 6'b000100;
  localparam logic [5:0] OPC_BLEU = 6'b010000;
  localparam logic [5:0] OPC_ROLV = 6'b000000;
  localparam logic [5:0] OPC_RORV = 6'b000010;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;
  localparam int TGT_HI = 25;
  localparam int TGT_LO = 0;

  function automatic logic [31:0] enc_r(input logic [5:0] opc, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
    logic [31:0] w;
    w = '0;
    w[OP_HI:OP_LO] = opc;
    w[RS_HI:RS_LO] = rs;
    w[RT_HI:RT_LO] = rt;
    w[RD_HI:RD_LO] = rd;
    return w;
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] opc, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    logic [31:0] w;
    w = '0;
    w[OP_HI:OP_LO]   = opc;
    w[RS_HI:RS_LO]   = rs;
    w[RT_HI:RT_LO]   = rt;
    w[IMM_HI:IMM_LO] = imm;
    return w;
  endfunction

endpackage

// File: rtl/ienc_pack.sv
// Combinational packer: symbolic op and fields -> 32-bit word, plus legality
// and immediate-fit flags.
module ienc_pack
  import ienc_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        legal,
  output logic        range_ok
);

  logic simm16_ok;
  logic uimm16_ok;
  logic tgt26_ok;

  // signed 16-bit fits when bits 31..15 are a pure sign extension
  assign simm16_ok = (&imm[31:15]) | ~(|imm[31:15]);
  assign uimm16_ok = ~(|imm[31:16]);
  assign tgt26_ok  = ~(|imm[31:26]);

  always_comb begin
    word     = '0;
    legal    = 1'b1;
    range_ok = 1'b1;
    case (op)
      OP_AND:  word = enc_r(OPC_AND, rs, rt, rd);
      OP_NOR:  word = enc_r(OPC_NOR, rs, rt, rd);
      OP_NOT:  word = enc_r(OPC_NOT, rs, rt, rd);
      OP_ROLV: word = enc_r(OPC_ROLV, rs, rt, rd);
      OP_RORV: word = enc_r(OPC_RORV, rs, rt, rd);
      OP_LW: begin
        word     = enc_i(OPC_LW, rs, rt, imm[15:0]);
        range_ok = simm16_ok;
      end
      OP_SW: begin
        word     = enc_i(OPC_SW, rs, rt, imm[15:0]);
        range_ok = simm16_ok;
      end
      OP_BLEU: begin
        word     = enc_i(OPC_BLEU, rs, rt, imm[15:0]);
        range_ok = simm16_ok;
      end
      OP_NORI: begin
        word     = enc_i(OPC_NORI, rs, rt, imm[15:0]);
        range_ok = uimm16_ok;
      end
      OP_JAL: begin
        word[OP_HI:OP_LO]   = OPC_JAL;
        word[TGT_HI:TGT_LO] = imm[25:0];
        range_ok            = tgt26_ok;
      end
      OP_JR: begin
        word[OP_HI:OP_LO] = OPC_JR;
        word[RS_HI:RS_LO] = rs;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Boot-time program loader: accepts symbolic instruction beats and writes the encoded
// words sequentially into imem. Define IENC_RANGE_CHECK_EN to drop out-of-range immediates.
module instr_encoder_loader
  import ienc_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic              err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  localparam logic [ADDR_W:0]   DEPTH_C   = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [1:0]        state_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] addr_next;
  logic [ADDR_W:0]   count_reg;
  logic [ADDR_W:0]   count_next;
  logic              we_reg;
  logic [ADDR_W-1:0] waddr_reg;
  logic [31:0]       wdata_reg;
  logic              err_reg;

  logic [31:0] word;
  logic        legal;
  logic        range_ok;
  logic        write_ok;
  logic        accept;
  logic        do_write;

  ienc_pack u_pack (
    .op       (in_op),
    .rs       (in_rs),
    .rt       (in_rt),
    .rd       (in_rd),
    .imm      (in_imm),
    .word     (word),
    .legal    (legal),
    .range_ok (range_ok)
  );

`ifdef IENC_RANGE_CHECK_EN
  assign write_ok = legal & range_ok;
`else
  logic unused_range_ok;
  assign unused_range_ok = range_ok;
  assign write_ok        = legal;
`endif

  assign in_ready   = (state_reg == S_LOAD) && (count_reg < DEPTH_C);
  assign accept     = in_valid & in_ready;
  assign do_write   = accept & write_ok;
  assign addr_next  = (addr_reg == LAST_ADDR) ? '0 : addr_reg + 1'b1;
  assign count_next = count_reg + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
      addr_reg  <= '0;
      count_reg <= '0;
      we_reg    <= 1'b0;
      waddr_reg <= '0;
      wdata_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      we_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            state_reg <= S_LOAD;
            addr_reg  <= base_addr;
            count_reg <= '0;
            err_reg   <= 1'b0;
          end
        end
        S_LOAD: begin
          if (accept) begin
            if (do_write) begin
              we_reg    <= 1'b1;
              waddr_reg <= addr_reg;
              wdata_reg <= word;
              addr_reg  <= addr_next;
              count_reg <= count_next;
            end else begin
              err_reg <= 1'b1;
            end
            // a filled memory without in_last means the program was truncated
            if (in_last) begin
              state_reg <= S_FLUSH;
            end else if (do_write && (count_next == DEPTH_C)) begin
              state_reg <= S_FLUSH;
              err_reg   <= 1'b1;
            end
          end
        end
        S_FLUSH: state_reg <= S_IDLE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign imem_we    = we_reg;
  assign imem_addr  = waddr_reg;
  assign imem_wdata = wdata_reg;
  assign busy       = (state_reg != S_IDLE);
  assign done       = (state_reg == S_FLUSH);
  assign count      = count_reg;
  assign err        = err_reg;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed self-checking bench for instr_encoder_loader with hand-computed words.
module tb_instr_encoder_loader;
  import ienc_pkg::*;

  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_op;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [31:0]       in_imm;
  logic              in_last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   count;
  logic              err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_rs      (in_rs),
    .in_rt      (in_rt),
    .in_rd      (in_rd),
    .in_imm     (in_imm),
    .in_last    (in_last),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .busy       (busy),
    .done       (done),
    .count      (count),
    .err        (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_prog(input logic [ADDR_W-1:0] base);
    base_addr = base;
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  // Returns one cycle after the accepting edge, when the write (if any) is visible.
  task automatic beat(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [31:0] imm, input logic last);
    in_op    = op;
    in_rs    = rs;
    in_rt    = rt;
    in_rd    = rd;
    in_imm   = imm;
    in_last  = last;
    in_valid = 1'b1;
    for (int n = 0; n < 16 && !in_ready; n++) step();
    if (!in_ready) begin
      check("ready_timeout", 32'(in_ready), 32'd1);
    end else begin
      step();
      $display("[TB] beat op=%0d last=%0b we=%0b addr=%0d wdata=0x%08h count=%0d",
               op, last, imem_we, imem_addr, imem_wdata, count);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expect_write(input string tag, input logic [ADDR_W-1:0] addr,
                              input logic [31:0] data);
    check({tag, "_we"}, 32'(imem_we), 32'd1);
    check({tag, "_addr"}, 32'(imem_addr), 32'(addr));
    check({tag, "_wdata"}, imem_wdata, data);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0;
    in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0; in_last = 1'b0;
    step(); step();
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    reset = 1'b0;
    step();

    // single lw, one-cycle latency
    start_prog(6'd0);
    check("load_busy", 32'(busy), 32'd1);
    check("load_ready", 32'(in_ready), 32'd1);
    beat(OP_LW, 5'd29, 5'd8, 5'd0, 32'd4, 1'b1);
    expect_write("lw", 6'd0, 32'h8FA8_0004);
    check("lw_done", 32'(done), 32'd1);
    check("lw_count", 32'(count), 32'd1);
    step();
    check("lw_done_pulse", 32'(done), 32'd0);
    check("lw_idle", 32'(busy), 32'd0);
    check("lw_we_off", 32'(imem_we), 32'd0);

    // and + jal; a start pulse mid-load must be ignored
    start_prog(6'd0);
    beat(OP_AND, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0);
    expect_write("and", 6'd0, 32'h8022_1800);
    check("and_done", 32'(done), 32'd0);
    start = 1'b1; base_addr = 6'd40;
    beat(OP_JAL, 5'd0, 5'd0, 5'd0, 32'h100, 1'b1);
    start = 1'b0;
    expect_write("jal", 6'd1, 32'h0C00_0100);
    check("jal_done", 32'(done), 32'd1);
    check("jal_count", 32'(count), 32'd2);
    step();

    // nori in range
    start_prog(6'd5);
    beat(OP_NORI, 5'd4, 5'd5, 5'd0, 32'hFFFF, 1'b1);
    expect_write("nori", 6'd5, 32'h3885_FFFF);
    check("nori_err", 32'(err), 32'd0);
    step();

    // nori out of range
    start_prog(6'd7);
    beat(OP_NORI, 5'd4, 5'd5, 5'd0, 32'h1_0000, 1'b1);
`ifdef IENC_RANGE_CHECK_EN
    check("nori_big_we", 32'(imem_we), 32'd0);
    check("nori_big_err", 32'(err), 32'd1);
`else
    expect_write("nori_big", 6'd7, 32'h3885_0000);
    check("nori_big_err", 32'(err), 32'd0);
`endif
    step();

    // undefined op: accepted, not written, err sticky until next start
    start_prog(6'd9);
    beat(4'd12, 5'd1, 5'd1, 5'd1, 32'd0, 1'b1);
    check("undef_we", 32'(imem_we), 32'd0);
    check("undef_err", 32'(err), 32'd1);
    check("undef_done", 32'(done), 32'd1);
    check("undef_count", 32'(count), 32'd0);
    step();
    check("undef_err_sticky", 32'(err), 32'd1);
    start_prog(6'd62);
    check("start_clears_err", 32'(err), 32'd0);

    // address wrap 62, 63, 0, 1
    beat(OP_SW, 5'd2, 5'd3, 5'd0, 32'd8, 1'b0);
    expect_write("wrap_sw", 6'd62, 32'hAC43_0008);
    beat(OP_JR, 5'd31, 5'd0, 5'd0, 32'd0, 1'b0);
    expect_write("wrap_jr", 6'd63, 32'h23E0_0000);
    beat(OP_NOR, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0);
    expect_write("wrap_nor", 6'd0, 32'h9822_1800);
    beat(OP_BLEU, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFC, 1'b1);
    expect_write("wrap_bleu", 6'd1, 32'h4022_FFFC);
    check("wrap_count", 32'(count), 32'd4);
    step();

    // remaining R-type opcodes
    start_prog(6'd20);
    beat(OP_ROLV, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0);
    expect_write("rolv", 6'd20, 32'h0022_1800);
    beat(OP_RORV, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0);
    expect_write("rorv", 6'd21, 32'h0822_1800);
    beat(OP_NOT, 5'd1, 5'd2, 5'd3, 32'd0, 1'b1);
    expect_write("not", 6'd22, 32'h1022_1800);
    step();

    // overflow: 64 writes without last, then beats are refused
    start_prog(6'd0);
    for (int i = 0; i < DEPTH; i++) begin
      beat(OP_LW, 5'd0, 5'd0, 5'd0, 32'(i), 1'b0);
      expect_write($sformatf("full%0d", i), 6'(i), 32'h8C00_0000 | 32'(i));
    end
    check("full_done", 32'(done), 32'd1);
    check("full_err", 32'(err), 32'd1);
    check("full_ready", 32'(in_ready), 32'd0);
    check("full_count", 32'(count), 32'd64);
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("full_drop_we%0d", k), 32'(imem_we), 32'd0);
      check($sformatf("full_drop_ready%0d", k), 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    check("full_done_pulse", 32'(done), 32'd0);

    // reset mid-load aborts with no done
    start_prog(6'd0);
    for (int i = 0; i < 3; i++) beat(OP_AND, 5'(i), 5'd2, 5'd3, 32'd0, 1'b0);
    check("abort_count_before", 32'(count), 32'd3);
    reset = 1'b1;
    step();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_we", 32'(imem_we), 32'd0);
    check("abort_count", 32'(count), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;
    step();
    check("abort_done_after", 32'(done), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
